// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and HI/LO funct decode for the multiply/divide unit
package mdu_pkg;
  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  function automatic logic is_mdu_funct(input logic [5:0] funct);
    return funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction
  function automatic logic [1:0] funct_to_op(input logic [5:0] funct);
    return funct[1:0];
  endfunction
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration, shift-add (multiply) or restoring shift-subtract (divide)
//   div: mode select; hi/lo: partial product or remainder/quotient; opd: multiplicand or divisor
//   hi_nxt/lo_nxt: state after this iteration
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opd,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH-1:0] rem;
  logic ge;
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    sh = {hi, lo[WIDTH-1]};
    ge = sh >= {1'b0, opd};
    // the remainder after a successful subtract always fits WIDTH bits
    rem = sh[WIDTH-1:0] - opd;
    hi_nxt = div ? (ge ? rem : sh[WIDTH-1:0]) : sum[WIDTH:1];
    lo_nxt = div ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
//   clk, rst (async, active-low); start/op/src_a/src_b issue an op; flush kills it
//   hi_we/lo_we/wdata: MTHI/MTLO; busy, done pulse, sticky div_by_zero; hi/lo registers
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opd, nxt_hi, nxt_lo, abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;
  logic is_div, neg_q, neg_r, dz, sgn, a_neg, b_neg, accept, op_div;
  always_comb begin
    op_div = op inside {MDU_DIV, MDU_DIVU};
    sgn = op inside {MDU_MULT, MDU_DIV};
    a_neg = sgn & src_a[WIDTH-1];
    b_neg = sgn & src_b[WIDTH-1];
    abs_a = a_neg ? -src_a : src_a;
    abs_b = b_neg ? -src_b : src_b;
    prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    busy = state != ST_IDLE;
    accept = start & ~busy & ~flush;
  end
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div    (is_div),
    .hi     (acc_hi),
    .lo     (acc_lo),
    .opd    (opd),
    .hi_nxt (nxt_hi),
    .lo_nxt (nxt_lo)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && flush) begin
        state <= ST_IDLE;
        cnt <= '0;
      end else if (state == ST_RUN) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        if (cnt == '0) state <= ST_FINAL;
        else cnt <= cnt - 1'b1;
      end else if (state == ST_FINAL) begin
        state <= ST_IDLE;
        done <= 1'b1;
        div_by_zero <= dz;
        // a zero divisor leaves |a| in the remainder, so sign-correcting it restores src_a
        hi <= is_div ? (neg_r ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
        lo <= is_div ? (dz ? '1 : neg_q ? -acc_lo : acc_lo) : prod[WIDTH-1:0];
      end else begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
        if (accept) begin
          state <= ST_RUN;
          cnt <= CNT_W'(WIDTH - 1);
          is_div <= op_div;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dz <= op_div && src_b == '0;
          div_by_zero <= 1'b0;
          acc_hi <= '0;
          acc_lo <= op_div ? abs_a : abs_b;
          opd <= op_div ? abs_b : abs_a;
        end
      end
    end
  end
endmodule
